// File: rtl/tw16_mul_pkg.sv
// Shared constants for the radix-2 16-point twiddle multiplier: default widths,
// W16 coefficient table (1.0 == 1024) and rounding parameters.
package tw16_mul_pkg;

    localparam int DEF_WIDTH    = 13;
    localparam int DEF_TW_WIDTH = 12;
    localparam int RND_CONST    = 512;
    localparam int RND_SHIFT    = 10;

    // W16^j = cos - i*sin, j = 0..7; C is the real part, D the imaginary part
    localparam logic signed [DEF_TW_WIDTH-1:0] W16_C [8] = '{
        12'sd1024, 12'sd946, 12'sd724, 12'sd392,
        12'sd0, -12'sd392, -12'sd724, -12'sd946
    };
    localparam logic signed [DEF_TW_WIDTH-1:0] W16_D [8] = '{
        12'sd0, -12'sd392, -12'sd724, -12'sd946,
        -12'sd1024, -12'sd946, -12'sd724, -12'sd392
    };

    // First half of a block is untwiddled; second half uses W16^(idx-8).
    function automatic logic [2:0] tw_index(input logic [3:0] idx);
        return idx[3] ? idx[2:0] : 3'd0;
    endfunction

endpackage

// File: rtl/tw16_mul_cmul_rs.sv
// Combinational add/subtract of two full-precision products, round-half-up by
// RND_CONST, arithmetic shift by RND_SHIFT and saturation to OW signed bits.
module cmul_rs
    import tw16_mul_pkg::*;
#(
    parameter int PW  = 26,
    parameter int OW  = 14,
    parameter bit SUB = 1'b0
) (
    input  logic signed [PW-1:0] p_a_i,
    input  logic signed [PW-1:0] p_b_i,
    output logic signed [OW-1:0] y_o
);

    // Two guard bits: one for the sum, one for the rounding add.
    localparam int SW = PW + 2;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (OW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (OW - 1)));

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] rnd;
    logic signed [SW-1:0] shifted;

    always_comb begin
        sum     = SUB ? (SW'(p_a_i) - SW'(p_b_i)) : (SW'(p_a_i) + SW'(p_b_i));
        rnd     = sum + SW'(RND_CONST);
        shifted = rnd >>> RND_SHIFT;
        if (shifted > SAT_MAX) begin
            y_o = SAT_MAX[OW-1:0];
        end else if (shifted < SAT_MIN) begin
            y_o = SAT_MIN[OW-1:0];
        end else begin
            y_o = shifted[OW-1:0];
        end
    end

endmodule

// File: rtl/tw16_mul.sv
// Twiddle multiplier following the span-8 butterfly: 3-stage pipeline that
// multiplies each sample by W16^j selected from its position in a 16-sample block.
module tw16_mul
    import tw16_mul_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TW_WIDTH = DEF_TW_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic signed [WIDTH:0]   data_in_re,
    input  logic signed [WIDTH:0]   data_in_im,
    output logic                    out_valid,
    output logic                    out_sof,
    output logic signed [WIDTH:0]   data_out_re,
    output logic signed [WIDTH:0]   data_out_im
);

    localparam int DW = WIDTH + 1;
    localparam int PW = DW + TW_WIDTH;

    logic [3:0] cnt_q, cnt_d;
    logic [3:0] idx;
    logic [2:0] tw_j;

    logic [2:0] vld_q;
    logic [2:0] sof_q;

    logic signed [DW-1:0]       a1_q, b1_q;
    logic signed [TW_WIDTH-1:0] c1_q, d1_q, c1_d, d1_d;

    logic signed [PW-1:0] ac_d, bd_d, ad_d, bc_d;
    logic signed [PW-1:0] ac_q, bd_q, ad_q, bc_q;

    logic signed [DW-1:0] re_d, im_d;
    logic signed [DW-1:0] re_q, im_q;

    // sof forces index 0 so a mid-block sof resynchronises the count.
    always_comb begin
        idx   = in_sof ? 4'd0 : cnt_q;
        cnt_d = in_valid ? (idx + 4'd1) : cnt_q;
        tw_j  = tw_index(idx);
        c1_d  = TW_WIDTH'(W16_C[tw_j]);
        d1_d  = TW_WIDTH'(W16_D[tw_j]);
    end

    always_comb begin
        ac_d = PW'(a1_q) * PW'(c1_q);
        bd_d = PW'(b1_q) * PW'(d1_q);
        ad_d = PW'(a1_q) * PW'(d1_q);
        bc_d = PW'(b1_q) * PW'(c1_q);
    end

    cmul_rs #(.PW(PW), .OW(DW), .SUB(1'b1)) u_rs_re (
        .p_a_i (ac_q),
        .p_b_i (bd_q),
        .y_o   (re_d)
    );

    cmul_rs #(.PW(PW), .OW(DW), .SUB(1'b0)) u_rs_im (
        .p_a_i (ad_q),
        .p_b_i (bc_q),
        .y_o   (im_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            vld_q <= '0;
            sof_q <= '0;
            a1_q  <= '0;
            b1_q  <= '0;
            c1_q  <= '0;
            d1_q  <= '0;
            ac_q  <= '0;
            bd_q  <= '0;
            ad_q  <= '0;
            bc_q  <= '0;
            re_q  <= '0;
            im_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= {vld_q[1:0], in_valid};
            sof_q <= {sof_q[1:0], in_valid & in_sof};
            if (in_valid) begin
                a1_q <= data_in_re;
                b1_q <= data_in_im;
                c1_q <= c1_d;
                d1_q <= d1_d;
            end
            if (vld_q[0]) begin
                ac_q <= ac_d;
                bd_q <= bd_d;
                ad_q <= ad_d;
                bc_q <= bc_d;
            end
            // Output registers only load on a valid result, holding otherwise.
            if (vld_q[1]) begin
                re_q <= re_d;
                im_q <= im_d;
            end
        end
    end

    assign out_valid   = vld_q[2];
    assign out_sof     = sof_q[2];
    assign data_out_re = re_q;
    assign data_out_im = im_q;

endmodule

// File: tb/tb_tw16_mul.sv
// Directed bench for tw16_mul: hand-computed twiddle vectors, reset behaviour,
// gaps and sof resync, with a cycle-stamped expected queue.
`timescale 1ns/1ps
module tb_tw16_mul;

    localparam int W = 13;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                in_valid = 1'b0;
    logic                in_sof   = 1'b0;
    logic signed [W:0]   data_in_re = '0;
    logic signed [W:0]   data_in_im = '0;
    logic                out_valid;
    logic                out_sof;
    logic signed [W:0]   data_out_re;
    logic signed [W:0]   data_out_im;

    tw16_mul dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .data_in_re  (data_in_re),
        .data_in_im  (data_in_im),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .data_out_re (data_out_re),
        .data_out_im (data_out_im)
    );

    // Scoreboard state
    typedef struct {
        int due;
        int sof;
        int re;
        int im;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   m_cnt   = 0;
    int   last_re = 0;
    int   last_im = 0;

    localparam int TB_C [8] = '{1024, 946, 724, 392, 0, -392, -724, -946};
    localparam int TB_D [8] = '{0, -392, -724, -946, -1024, -946, -724, -392};

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int round_sat(input longint s);
        longint r;
        r = (s + 64'sd512) >>> 10;
        if (r > 8191) r = 8191;
        else if (r < -8192) r = -8192;
        return int'(r);
    endfunction

    // Driver tasks
    task automatic send(input bit sof, input int re, input int im,
                        input bit hand, input int hre, input int him);
        int   idx;
        int   j;
        exp_t e;
        @(negedge clk);
        in_valid   = 1'b1;
        in_sof     = sof;
        data_in_re = 14'(re);
        data_in_im = 14'(im);
        idx   = sof ? 0 : m_cnt;
        m_cnt = (idx + 1) % 16;
        j     = (idx >= 8) ? idx - 8 : 0;
        e.due = cyc + 3;
        e.sof = int'(sof);
        if (hand) begin
            e.re = hre;
            e.im = him;
        end else begin
            e.re = round_sat(longint'(re) * TB_C[j] - longint'(im) * TB_D[j]);
            e.im = round_sat(longint'(re) * TB_D[j] + longint'(im) * TB_C[j]);
        end
        exp_q.push_back(e);
    endtask

    task automatic send_rand(input bit sof);
        int re;
        int im;
        re = int'($urandom_range(0, 16383)) - 8192;
        im = int'($urandom_range(0, 16383)) - 8192;
        send(sof, re, im, 1'b0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid   = 1'b0;
            in_sof     = 1'($urandom_range(0, 1));
            data_in_re = 14'($urandom_range(0, 16383));
            data_in_im = 14'($urandom_range(0, 16383));
        end
    endtask

    // Monitor: results due this cycle must appear; otherwise outputs idle and hold.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_re = 0;
            last_im = 0;
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("out_valid", int'(out_valid), 1);
            check("out_sof", int'(out_sof), e.sof);
            check("data_out_re", data_out_re, e.re);
            check("data_out_im", data_out_im, e.im);
            last_re = e.re;
            last_im = e.im;
        end else begin
            check("idle_valid", int'(out_valid), 0);
            check("hold_re", data_out_re, last_re);
            check("hold_im", data_out_im, last_im);
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_sof", int'(out_sof), 0);
        check("rst_re", data_out_re, 0);
        check("rst_im", data_out_im, 0);
        #1 rst = 1'b0;

        // Block 1: identity at index 0, j=2 at index 10, j=4 at index 12
        send(1'b1, 1000, -500, 1'b1, 1000, -500);
        for (int i = 1; i <= 9; i++) send_rand(1'b0);
        send(1'b0, 1024, 0, 1'b1, 724, -724);
        send_rand(1'b0);
        send(1'b0, 1000, 200, 1'b1, 200, -1000);
        idle(2);
        for (int i = 13; i <= 15; i++) send_rand(1'b0);

        // Block 2: saturation at index 12 plus extreme corners, wrapped via count
        send_rand(1'b0);
        for (int i = 1; i <= 11; i++) begin
            send_rand(1'b0);
            if (i % 4 == 0) idle(1);
        end
        send(1'b0, -8192, 0, 1'b1, 0, 8191);
        send(1'b0, 8191, 8191, 1'b0, 0, 0);
        send(1'b0, -8192, -8192, 1'b0, 0, 0);
        send(1'b0, 8191, -8192, 1'b0, 0, 0);
        idle(3);

        // Reset mid-block with results in flight, count at 11
        send(1'b1, 3000, -3000, 1'b0, 0, 0);
        for (int i = 1; i <= 10; i++) send_rand(1'b0);
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_sof", int'(out_sof), 0);
        check("async_rst_re", data_out_re, 0);
        check("async_rst_im", data_out_im, 0);
        exp_q.delete();
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // First sample after reset is index 0 even without sof
        send(1'b0, 1000, 200, 1'b1, 1000, 200);
        for (int i = 1; i <= 15; i++) send_rand(1'b0);

        // Random gaps, then sof at index 5 restarts the block
        for (int i = 0; i < 16; i++) begin
            send_rand(i == 0);
            idle(int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 5; i++) send_rand(1'b0);
        send_rand(1'b1);
        for (int i = 1; i < 16; i++) begin
            send_rand(1'b0);
            idle(int'($urandom_range(0, 2)));
        end
        idle(1);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
